// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, MIPS32 opcode/funct values,
// the issue FSM state type and the decoded-operation record.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FULL    = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  alu_control;
    logic        b_sel_imm;
    logic        a_sel_rt;
    logic [31:0] imm_ext;
    logic        is_md;
    logic        is_illegal;
  } decode_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / ALU-operation-out bundle of the issue controller.
// valid/ready: a transfer happens on a rising edge where both are high; a source holding
// valid keeps its payload stable until that edge, and ready may depend combinationally on valid.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic        b_sel_imm;
  logic        a_sel_rt;
  logic [31:0] imm_ext;
  logic        md_busy;
  logic        md_done;
  logic        illegal;

  modport master (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_control, b_sel_imm, a_sel_rt, imm_ext,
           md_busy, md_done, illegal
  );

  modport slave (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_control, b_sel_imm, a_sel_rt, imm_ext,
           md_busy, md_done, illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS32 decode: instruction word -> ALU code, operand selects, extended
// immediate, mult/div flag and unlisted-encoding flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] sext;
  logic [31:0] zext;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign sext   = {{16{instr[15]}}, instr[15:0]};
  assign zext   = {16'h0000, instr[15:0]};

  always_comb begin
    dec             = '0;
    dec.alu_control = ALU_ADD;
    dec.imm_ext     = sext;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_AND:          dec.alu_control = ALU_AND;
        FN_OR:           dec.alu_control = ALU_OR;
        FN_NOR:          dec.alu_control = ALU_NOR;
        FN_XOR:          dec.alu_control = ALU_XOR;
        FN_ADD, FN_ADDU: dec.alu_control = ALU_ADD;
        FN_SUB, FN_SUBU: dec.alu_control = ALU_SUB;
        FN_SLT:          dec.alu_control = ALU_SLT;
        FN_SLL:          dec.alu_control = ALU_SLL;
        FN_SRL:          dec.alu_control = ALU_SRL;
        FN_SRA:          dec.alu_control = ALU_SRA;
        FN_MULT:         dec.alu_control = ALU_MULT;
        FN_DIV:          dec.alu_control = ALU_DIV;
        default:         dec.is_illegal  = 1'b1;
      endcase
      // Shifts take rt as operand a and read shamt out of imm_ext[10:6].
      if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
        dec.a_sel_rt  = 1'b1;
        dec.b_sel_imm = 1'b1;
        dec.imm_ext   = zext;
      end
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
          dec.alu_control = ALU_ADD;
          dec.b_sel_imm   = 1'b1;
        end
        OP_SLTI: begin
          dec.alu_control = ALU_SLT;
          dec.b_sel_imm   = 1'b1;
        end
        OP_ANDI: begin
          dec.alu_control = ALU_AND;
          dec.b_sel_imm   = 1'b1;
          dec.imm_ext     = zext;
        end
        OP_ORI: begin
          dec.alu_control = ALU_OR;
          dec.b_sel_imm   = 1'b1;
          dec.imm_ext     = zext;
        end
        OP_XORI: begin
          dec.alu_control = ALU_XOR;
          dec.b_sel_imm   = 1'b1;
          dec.imm_ext     = zext;
        end
        OP_BEQ, OP_BNE:  dec.alu_control = ALU_SUB;
        default:         dec.is_illegal  = 1'b1;
      endcase
    end
    dec.is_md = (dec.alu_control == ALU_MULT) || (dec.alu_control == ALU_DIV);
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// One-entry registered issue stage between fetch and the ALU, with a fixed stall after mult/div.
// Optional trap of unlisted encodings: define ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_issue_ctrl_if.master    bus,
  output state_t              state_dbg
);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  decode_t     dec;
  logic [3:0]  alu_q;
  logic        b_sel_q;
  logic        a_sel_q;
  logic [31:0] imm_q;
  logic        md_q;
  logic        in_ready_c, out_valid_c, md_busy_c, md_done_c;
  logic        accept, fire, trap, load;

  alu_ctrl_decode u_decode (
    .instr (bus.instr),
    .dec   (dec)
  );

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap = dec.is_illegal;
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= accept & trap;
  end
  assign bus.illegal = illegal_q;
`else
  logic trap_unused;
  assign trap_unused = dec.is_illegal;
  assign trap        = 1'b0;
  assign bus.illegal = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    md_busy_c   = 1'b0;
    md_done_c   = 1'b0;
    case (state_q)
      IDLE:    in_ready_c = 1'b1;
      FULL: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready & ~md_q;
      end
      MD_WAIT: begin
        md_busy_c = 1'b1;
        md_done_c = (cnt_q == 4'd0);
      end
      default: ;
    endcase

    accept = bus.in_valid & in_ready_c;
    fire   = out_valid_c & bus.out_ready;
    // A trapped encoding is accepted off the bus but never reaches the output register.
    load   = accept & ~trap;

    case (state_q)
      IDLE: if (load) state_d = FULL;
      FULL: begin
        if (fire && md_q) begin
          state_d = MD_WAIT;
          cnt_d   = 4'(MD_LATENCY - 1);
        end else if (fire) begin
          state_d = load ? FULL : IDLE;
        end
      end
      MD_WAIT: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      alu_q   <= ALU_ADD;
      b_sel_q <= 1'b0;
      a_sel_q <= 1'b0;
      imm_q   <= 32'd0;
      md_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        alu_q   <= dec.alu_control;
        b_sel_q <= dec.b_sel_imm;
        a_sel_q <= dec.a_sel_rt;
        imm_q   <= dec.imm_ext;
        md_q    <= dec.is_md;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.md_busy     = md_busy_c;
  assign bus.md_done     = md_done_c;
  assign bus.alu_control = alu_q;
  assign bus.b_sel_imm   = b_sel_q;
  assign bus.a_sel_rt    = a_sel_q;
  assign bus.imm_ext     = imm_q;
  assign state_dbg       = state_q;
endmodule
